// File: rtl/svo_tmds_dec.sv
// TMDS receive decoder and word aligner for one channel: searches the bit
// offset that yields control-token runs, then decodes aligned symbols.
module svo_tmds_dec #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_WIN     = 64,
  parameter int UNLOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int SW_W = $clog2(SEARCH_WIN);
  localparam int UT_W = $clog2(UNLOCK_TIMEOUT);
  localparam int TW   = (SW_W > UT_W) ? ((SW_W > 0) ? SW_W : 1) : ((UT_W > 0) ? UT_W : 1);
  localparam int RW   = ($clog2(LOCK_TOKENS) > 0) ? $clog2(LOCK_TOKENS) : 1;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t          state;
  logic [9:0]      prev;
  logic [RW-1:0]   run;
  logic [TW-1:0]   timer;

  logic [19:0]     window;
  logic [9:0]      w;
  logic            is_tok;
  logic [1:0]      tok_val;
  logic [7:0]      dec_dout;
  logic [1:0]      dec_ctrl;
  logic            dec_de;

  function automatic logic [7:0] tmds_data(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] q;
    d    = s[9] ? ~s[7:0] : s[7:0];
    q    = '0;
    q[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return q;
  endfunction

  // offset 0 selects prev alone, so the aligned word lags din by one cycle
  always_comb begin
    window = {din, prev};
    w      = 10'(window >> offset);
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    unique case (w)
      TOK_00:  tok_val = 2'b00;
      TOK_01:  tok_val = 2'b01;
      TOK_10:  tok_val = 2'b10;
      TOK_11:  tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  // Next decoded outputs; token symbols hold dout, data symbols hold ctrl.
  always_comb begin
    dec_dout = dout;
    dec_ctrl = ctrl;
    dec_de   = 1'b0;
    if (is_tok) begin
      dec_ctrl = tok_val;
    end else begin
      dec_de   = 1'b1;
      dec_dout = tmds_data(w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_SEARCH;
      prev   <= '0;
      run    <= '0;
      timer  <= '0;
      offset <= '0;
      locked <= 1'b0;
      dout   <= '0;
      ctrl   <= '0;
      de     <= 1'b0;
    end else begin
      prev <= din;
      unique case (state)
        S_SEARCH: begin
          // a lock on the last cycle of the window takes priority over the slip
          if (is_tok && run == RW'(LOCK_TOKENS - 1)) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
            run    <= '0;
            timer  <= '0;
            dout   <= dec_dout;
            ctrl   <= dec_ctrl;
            de     <= dec_de;
          end else begin
            if (timer == TW'(SEARCH_WIN - 1)) begin
              offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
              run    <= '0;
              timer  <= '0;
            end else begin
              run    <= is_tok ? run + RW'(1) : '0;
              timer  <= timer + TW'(1);
            end
            dout <= '0;
            ctrl <= '0;
            de   <= 1'b0;
          end
        end
        S_LOCKED: begin
          if (!is_tok && timer == TW'(UNLOCK_TIMEOUT - 1)) begin
            state  <= S_SEARCH;
            locked <= 1'b0;
            run    <= '0;
            timer  <= '0;
            dout   <= '0;
            ctrl   <= '0;
            de     <= 1'b0;
          end else begin
            timer <= is_tok ? '0 : timer + TW'(1);
            dout  <= dec_dout;
            ctrl  <= dec_ctrl;
            de    <= dec_de;
          end
        end
        default: state <= S_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Self-checking bench for svo_tmds_dec: reset, aligned/misaligned lock,
// encoder round-trip through a scoreboard, unlock timeout and corner cases.
module tb_svo_tmds_dec;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] din;
  logic [7:0] dout;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  int checks = 0;
  int errors = 0;
  int enc_cnt = 0;

  always #5 clk = ~clk;

  svo_tmds_dec #(.LOCK_TOKENS(8), .SEARCH_WIN(64), .UNLOCK_TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .ctrl(ctrl),
    .de(de), .locked(locked), .offset(offset)
  );

  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dout;
  } exp_t;

  typedef struct packed {
    logic chk;
    exp_t e;
  } sb_t;

  typedef struct {
    logic       is_tok;
    logic [1:0] c;
    logic [7:0] d;
    logic       e_de;
    logic [1:0] e_ctrl;
    logic [7:0] e_dout;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[9];

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // DVI-style encoder with running disparity
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) enc_cnt = enc_cnt + n1q - n0q;
      else       enc_cnt = enc_cnt + n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [9:0] word);
    din = word;
    @(posedge clk);
    #1;
  endtask

  // Entry pushed for word n is compared once the output for word n is present.
  task automatic sb_step(input logic [9:0] word, input logic chk, input exp_t e);
    sb_t ent;
    din = word;
    sb.push_back({chk, e});
    @(posedge clk);
    #1;
    if (sb.size() > 1) begin
      ent = sb.pop_front();
      if (ent.chk) check("decode", {de, ctrl, dout}, ent.e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(10'($urandom));
    check("rst_dout", dout, 8'h00);
    check("rst_ctrl", ctrl, 2'b00);
    check("rst_de", de, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_offset", offset, 4'd0);
    reset = 1'b0;
    sb.delete();
    enc_cnt = 0;
  endtask

  initial begin
    logic [7:0] last_d;
    logic [7:0] rd;
    logic [9:0] rot;

    vecs[0] = '{1'b0, 2'b00, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[1] = '{1'b0, 2'b00, 8'hFF, 1'b1, 2'b00, 8'hFF};
    vecs[2] = '{1'b0, 2'b00, 8'h55, 1'b1, 2'b00, 8'h55};
    vecs[3] = '{1'b0, 2'b00, 8'hA5, 1'b1, 2'b00, 8'hA5};
    vecs[4] = '{1'b1, 2'b10, 8'h00, 1'b0, 2'b10, 8'hA5};
    vecs[5] = '{1'b1, 2'b11, 8'h00, 1'b0, 2'b11, 8'hA5};
    vecs[6] = '{1'b0, 2'b00, 8'h3C, 1'b1, 2'b11, 8'h3C};
    vecs[7] = '{1'b1, 2'b01, 8'h00, 1'b0, 2'b01, 8'h3C};
    vecs[8] = '{1'b1, 2'b00, 8'h00, 1'b0, 2'b00, 8'h3C};

    din = '0;
    do_reset();

    // aligned lock: 8th token as w in cycle 8, locked visible in cycle 9
    for (int j = 0; j < 20; j++) begin
      step(tok(2'b00));
      if (j == 7) check("align_not_yet", locked, 1'b0);
      if (j == 8) check("align_locked", locked, 1'b1);
    end
    check("align_offset", offset, 4'd0);
    check("align_ctrl", ctrl, 2'b00);
    check("align_de", de, 1'b0);

    // table-driven round trip
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_tok) begin
        enc_cnt = 0;
        sb_step(tok(vecs[i].c), 1'b1, {vecs[i].e_de, vecs[i].e_ctrl, vecs[i].e_dout});
      end else begin
        sb_step(tmds_enc(vecs[i].d), 1'b1, {vecs[i].e_de, vecs[i].e_ctrl, vecs[i].e_dout});
      end
    end
    last_d = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      rd = 8'($urandom_range(0, 255));
      sb_step(tmds_enc(rd), 1'b1, {1'b1, 2'b00, rd});
      last_d = rd;
    end
    enc_cnt = 0;
    sb_step(tok(2'b10), 1'b1, {1'b0, 2'b10, last_d});
    sb_step(tok(2'b10), 1'b1, {1'b0, 2'b10, last_d});
    sb.delete();

    // unlock after 4096 consecutive data symbols
    for (int i = 0; i < 4096; i++) step(tmds_enc(8'($urandom_range(0, 255))));
    check("unlock_still_locked", locked, 1'b1);
    step(tok(2'b11));
    check("unlock_dropped", locked, 1'b0);
    check("unlock_de", de, 1'b0);
    check("unlock_dout", dout, 8'h00);
    check("unlock_offset", offset, 4'd0);
    for (int i = 0; i < 10; i++) step(tok(2'b11));
    check("relock", locked, 1'b1);
    check("relock_offset", offset, 4'd0);
    check("relock_ctrl", ctrl, 2'b11);

    // run of exactly 7 tokens interrupted by data
    do_reset();
    for (int j = 0; j < 20; j++) begin
      step((j < 7) ? tok(2'b01) : tmds_enc(8'h42));
      check("run7_no_lock", locked, 1'b0);
    end

    // 8th token lands on the last cycle of the search window
    do_reset();
    for (int j = 0; j < 70; j++) begin
      step((j < 55) ? 10'h000 : tok(2'b10));
      if (j == 62) check("win_edge_not_yet", locked, 1'b0);
      if (j == 63) begin
        check("win_edge_locked", locked, 1'b1);
        check("win_edge_offset", offset, 4'd0);
        check("win_edge_ctrl", ctrl, 2'b10);
      end
    end

    // misaligned stream: token delayed by 3 serial bits
    do_reset();
    begin
      logic [9:0] t;
      t = tok(2'b01);
      rot = {t[6:0], t[9:7]};
    end
    for (int j = 0; j < 205; j++) begin
      step(rot);
      if (j == 62)  check("mis_offset_0", offset, 4'd0);
      if (j == 63)  check("mis_offset_1", offset, 4'd1);
      if (j == 127) check("mis_offset_2", offset, 4'd2);
      if (j == 191) check("mis_offset_3", offset, 4'd3);
      if (j == 198) check("mis_not_yet", locked, 1'b0);
      if (j == 199) begin
        check("mis_locked", locked, 1'b1);
        check("mis_ctrl", ctrl, 2'b01);
        check("mis_de", de, 1'b0);
      end
    end
    check("mis_offset_final", offset, 4'd3);

    // reset pulse while locked
    reset = 1'b1;
    step(rot);
    reset = 1'b0;
    check("pulse_locked", locked, 1'b0);
    check("pulse_offset", offset, 4'd0);
    check("pulse_ctrl", ctrl, 2'b00);
    check("pulse_de", de, 1'b0);
    check("pulse_dout", dout, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
